// File: rtl/button_event_decoder_if.sv
// Signal bundle between the button event decoder and its neighbours: the debounced
// level comes in, the event ticks and the busy flag go out.
interface button_event_decoder_if;
  logic db_level;
  logic single_tick;
  logic double_tick;
  logic long_tick;
  logic busy;

  modport slave (
    input  db_level,
    output single_tick,
    output double_tick,
    output long_tick,
    output busy
  );

  modport master (
    output db_level,
    input  single_tick,
    input  double_tick,
    input  long_tick,
    input  busy
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle single-click, double-click and
// long-press pulses, timing presses and gaps with a single shared up-counter.
module button_event_decoder #(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned LONG_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES  = 12_500_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  button_event_decoder_if.slave evt
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             single_q, single_d;
  logic             double_q, double_d;
  logic             long_q, long_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (evt.db_level) begin
          state_d = PRESS1;
          cnt_d   = CNT_ONE;
        end
      end

      PRESS1: begin
        if (evt.db_level) begin
          if (cnt_q == LONG_LAST) begin
            state_d = LONG;
            long_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = GAP;
          cnt_d   = CNT_ONE;
        end
      end

      // A press arriving on the last gap sample still counts as the second click.
      GAP: begin
        if (evt.db_level) begin
          state_d  = PRESS2;
          double_d = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d  = IDLE;
          single_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PRESS2: begin
        if (!evt.db_level) state_d = IDLE;
      end

      LONG: begin
        if (!evt.db_level) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign evt.single_tick = single_q;
  assign evt.double_tick = double_q;
  assign evt.long_tick   = long_q;
  assign evt.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_CYCLES=8 and GAP_CYCLES=5.
module tb_button_event_decoder;

  logic clk;
  logic reset_n;

  button_event_decoder_if bus ();

  button_event_decoder #(
    .CNT_W      (24),
    .LONG_CYCLES(8),
    .GAP_CYCLES (5)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .evt    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk  = 0;
  int nfail = 0;

  // step index within the current scenario, tick counts and the step of the last tick
  int t, sc, dc, lc, s_at, d_at, l_at, multi;

  task automatic check(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    t = 0; sc = 0; dc = 0; lc = 0;
    s_at = -1; d_at = -1; l_at = -1;
  endtask

  // Present `level` for n clock edges; outputs are sampled 1 ns after each edge.
  task automatic drive(input logic level, input int n);
    for (int i = 0; i < n; i++) begin
      bus.db_level = level;
      @(posedge clk);
      #1;
      if (bus.single_tick) begin sc++; s_at = t; end
      if (bus.double_tick) begin dc++; d_at = t; end
      if (bus.long_tick)   begin lc++; l_at = t; end
      if ((int'(bus.single_tick) + int'(bus.double_tick) + int'(bus.long_tick)) > 1) multi++;
      t++;
    end
  endtask

  int ticks_now;

  initial begin
    multi        = 0;
    reset_n      = 1'b0;
    bus.db_level = 1'b0;
    clr();
    #1;
    ticks_now = int'(bus.single_tick) + int'(bus.double_tick) + int'(bus.long_tick);
    check("reset_ticks", ticks_now, 0);
    check("reset_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // short press: 3 high, 5 low
    clr();
    drive(1'b1, 1);
    check("short_busy_rise", int'(bus.busy), 1);
    drive(1'b1, 2);
    drive(1'b0, 5);
    check("short_single_cnt", sc, 1);
    check("short_single_at", s_at, 7);
    check("short_busy_fall", int'(bus.busy), 0);
    drive(1'b0, 3);
    check("short_other_ticks", dc + lc, 0);
    check("short_single_once", sc, 1);

    // long press: 8 high, hold 20, release
    clr();
    drive(1'b1, 8);
    check("long_cnt", lc, 1);
    check("long_at", l_at, 7);
    drive(1'b1, 20);
    check("long_no_repeat", lc, 1);
    drive(1'b0, 1);
    check("long_release_busy", int'(bus.busy), 0);
    drive(1'b0, 10);
    check("long_no_single", sc + dc, 0);

    // long/short boundary: 7 high is still a short press
    clr();
    drive(1'b1, 7);
    drive(1'b0, 5);
    check("bound_no_long", lc, 0);
    check("bound_single_cnt", sc, 1);
    check("bound_single_at", s_at, 11);
    drive(1'b0, 2);

    // double click: 3 high, 2 low, 4 high, release
    clr();
    drive(1'b1, 3);
    drive(1'b0, 2);
    drive(1'b1, 4);
    check("dbl_cnt", dc, 1);
    check("dbl_at", d_at, 5);
    check("dbl_no_long", lc, 0);
    drive(1'b0, 1);
    check("dbl_release_busy", int'(bus.busy), 0);
    drive(1'b0, 10);
    check("dbl_no_single", sc, 0);

    // gap boundary: 4 low then high is still a double click
    clr();
    drive(1'b1, 2);
    drive(1'b0, 4);
    drive(1'b1, 1);
    check("gap4_dbl_cnt", dc, 1);
    check("gap4_dbl_at", d_at, 6);
    drive(1'b0, 8);
    check("gap4_no_single", sc, 0);
    check("gap4_busy", int'(bus.busy), 0);

    // gap boundary: 5 low closes the window, next high is a fresh press
    clr();
    drive(1'b1, 2);
    drive(1'b0, 5);
    check("gap5_single_at", s_at, 6);
    drive(1'b1, 1);
    check("gap5_new_press_busy", int'(bus.busy), 1);
    check("gap5_no_dbl", dc, 0);
    drive(1'b0, 5);
    check("gap5_second_single", sc, 2);
    check("gap5_second_at", s_at, 12);

    // asynchronous reset while long_tick is high
    clr();
    drive(1'b1, 8);
    check("rst_long_pre", int'(bus.long_tick), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_long_tick_async", int'(bus.long_tick), 0);
    check("rst_long_busy_async", int'(bus.busy), 0);
    bus.db_level = 1'b1;
    #3;
    reset_n = 1'b1;
    // level already high at release: press begins at the first edge
    clr();
    drive(1'b1, 8);
    check("rst_hi_release_long_at", l_at, 7);
    drive(1'b0, 3);

    // asynchronous reset while in GAP
    clr();
    drive(1'b1, 2);
    drive(1'b0, 2);
    check("rst_gap_busy_pre", int'(bus.busy), 1);
    #3;
    reset_n = 1'b0;
    #1;
    ticks_now = int'(bus.single_tick) + int'(bus.double_tick) + int'(bus.long_tick);
    check("rst_gap_ticks_async", ticks_now, 0);
    check("rst_gap_busy_async", int'(bus.busy), 0);
    #2;
    reset_n = 1'b1;
    clr();
    drive(1'b0, 20);
    check("rst_gap_no_ticks", sc + dc + lc, 0);
    check("rst_gap_busy_after", int'(bus.busy), 0);

    check("one_tick_per_cycle", multi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
